// File: rtl/unibus_int_arb.sv
// Unibus interrupt arbiter: picks the highest-level eligible device request, posts its vector
// to the CPU and returns the CPU acknowledge as a one-cycle dev_ack. Optional: UNIBUS_INT_PREEMPT_EN.
module unibus_int_arb #(
  parameter int unsigned          N_DEV      = 4,
  parameter logic [3*N_DEV-1:0]   DEV_LEVELS = 12'o4654
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_DEV-1:0]     dev_int_i,
  input  logic [8*N_DEV-1:0]   dev_vector_i,
  output logic [N_DEV-1:0]     dev_ack_o,
  input  logic [2:0]           cpu_ipl_i,
  output logic                 cpu_int_o,
  output logic [7:0]           cpu_vector_o,
  output logic [2:0]           cpu_level_o,
  input  logic                 cpu_ack_i
);

  localparam int unsigned IdxW = (N_DEV > 1) ? $clog2(N_DEV) : 1;

  typedef enum logic [1:0] {StIdle, StPosted, StAck, StGuard} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] win_q, win_d;
  logic [7:0]      vec_q, vec_d;
  logic [2:0]      lvl_q, lvl_d;

  logic            best_vld;
  logic [IdxW-1:0] best_idx;
  logic [2:0]      best_lvl;
  logic [7:0]      best_vec;

  // Strict '>' on the running best keeps the lowest index on a level tie.
  always_comb begin
    best_vld = 1'b0;
    best_idx = '0;
    best_lvl = '0;
    best_vec = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (dev_int_i[i] && (DEV_LEVELS[3*i +: 3] > cpu_ipl_i) &&
          (!best_vld || (DEV_LEVELS[3*i +: 3] > best_lvl))) begin
        best_vld = 1'b1;
        best_idx = IdxW'(i);
        best_lvl = DEV_LEVELS[3*i +: 3];
        best_vec = dev_vector_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    vec_d   = vec_q;
    lvl_d   = lvl_q;
    unique case (state_q)
      StIdle: begin
        if (best_vld) begin
          state_d = StPosted;
          win_d   = best_idx;
          vec_d   = best_vec;
          lvl_d   = best_lvl;
        end
      end
      StPosted: begin
        // An ack wins over withdrawal: the CPU has already consumed the vector.
        if (cpu_ack_i) begin
          state_d = StAck;
        end else if (!dev_int_i[win_q] || (cpu_ipl_i >= lvl_q)) begin
          state_d = StIdle;
`ifdef UNIBUS_INT_PREEMPT_EN
        end else if (best_vld && (best_lvl > lvl_q)) begin
          win_d = best_idx;
          vec_d = best_vec;
          lvl_d = best_lvl;
`endif
        end
      end
      StAck:   state_d = StGuard;
      StGuard: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      win_q   <= '0;
      vec_q   <= '0;
      lvl_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      vec_q   <= vec_d;
      lvl_q   <= lvl_d;
    end
  end

  always_comb begin
    dev_ack_o    = '0;
    cpu_int_o    = 1'b0;
    cpu_vector_o = '0;
    cpu_level_o  = '0;
    if (state_q == StPosted) begin
      cpu_int_o    = 1'b1;
      cpu_vector_o = vec_q;
      cpu_level_o  = lvl_q;
    end else if (state_q == StAck) begin
      dev_ack_o[win_q] = 1'b1;
      cpu_vector_o     = vec_q;
      cpu_level_o      = lvl_q;
    end
  end

endmodule

// File: tb/tb_unibus_int_arb.sv
// Self-checking bench for unibus_int_arb: expected grants are queued as acks are issued and
// matched against dev_ack pulses by a monitor; direct checks cover latency, masking and reset.
module tb_unibus_int_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  dev_int;
  logic [31:0] dev_vector;
  logic [3:0]  dev_ack;
  logic [2:0]  cpu_ipl;
  logic        cpu_int;
  logic [7:0]  cpu_vector;
  logic [2:0]  cpu_level;
  logic        cpu_ack;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         dev;
    logic [7:0] vec;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [3:0] ack_prev = '0;

  always #5 clk = ~clk;

  unibus_int_arb dut (
    .clk          (clk),
    .reset        (reset),
    .dev_int_i    (dev_int),
    .dev_vector_i (dev_vector),
    .dev_ack_o    (dev_ack),
    .cpu_ipl_i    (cpu_ipl),
    .cpu_int_o    (cpu_int),
    .cpu_vector_o (cpu_vector),
    .cpu_level_o  (cpu_level),
    .cpu_ack_i    (cpu_ack)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every dev_ack pulse must be a single cycle and match the oldest queued grant.
  always @(negedge clk) begin
    if (dev_ack != '0) begin
      check_val("ack_len", {28'd0, ack_prev}, 32'd0);
      if (sb_q.size() == 0) begin
        check_val("ack_unexpected", {28'd0, dev_ack}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("sb_ack_dev", {28'd0, dev_ack}, 32'd1 << mon_e.dev);
        check_val("sb_ack_vec", {24'd0, cpu_vector}, {24'd0, mon_e.vec});
      end
    end
    ack_prev = dev_ack;
  end

  task automatic wait_post();
    for (int k = 0; k < 8 && !cpu_int; k++) tick();
    check_val("post_seen", {31'd0, cpu_int}, 32'd1);
  endtask

  task automatic grant(input int d, input logic [7:0] v, input logic [2:0] l);
    exp_t e;
    wait_post();
    check_val("post_vec", {24'd0, cpu_vector}, {24'd0, v});
    check_val("post_lvl", {29'd0, cpu_level}, {29'd0, l});
    e.dev = d;
    e.vec = v;
    sb_q.push_back(e);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    check_val("ack_cpu_int", {31'd0, cpu_int}, 32'd0);
    check_val("ack_onehot", {28'd0, dev_ack}, 32'd1 << d);
    check_val("ack_vec_held", {24'd0, cpu_vector}, {24'd0, v});
    dev_int[d] = 1'b0;
    tick();
    check_val("guard_int", {31'd0, cpu_int}, 32'd0);
    check_val("guard_vec", {24'd0, cpu_vector}, 32'd0);
    check_val("guard_lvl", {29'd0, cpu_level}, 32'd0);
    check_val("guard_ack", {28'd0, dev_ack}, 32'd0);
    tick();
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_int"}, {31'd0, cpu_int}, 32'd0);
    check_val({tag, "_vec"}, {24'd0, cpu_vector}, 32'd0);
    check_val({tag, "_lvl"}, {29'd0, cpu_level}, 32'd0);
    check_val({tag, "_ack"}, {28'd0, dev_ack}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    dev_int    = '0;
    dev_vector = '0;
    cpu_ipl    = '0;
    cpu_ack    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_idle("reset");

    // Single request, 1-cycle latency, vector stable while posted.
    dev_vector[7:0] = 8'o64;
    dev_int         = 4'b0001;
    tick();
    check_val("single_lat", {31'd0, cpu_int}, 32'd1);
    tick();
    tick();
    check_val("single_stable", {24'd0, cpu_vector}, {24'd0, 8'o64});
    grant(0, 8'o64, 3'd4);

    // Priority then tie by lowest index.
    dev_vector = {8'o300, 8'o100, 8'o220, 8'o60};
    dev_int    = 4'b1111;
    grant(2, 8'o100, 3'd6);
    grant(1, 8'o220, 3'd5);
    grant(0, 8'o60,  3'd4);
    grant(3, 8'o300, 3'd4);

    // IPL masking and withdrawal by raising IPL.
    cpu_ipl = 3'd5;
    dev_int = 4'b0011;
    tick();
    tick();
    tick();
    check_val("ipl_masked", {31'd0, cpu_int}, 32'd0);
    cpu_ipl = 3'd4;
    tick();
    check_val("ipl_post", {31'd0, cpu_int}, 32'd1);
    check_val("ipl_vec", {24'd0, cpu_vector}, {24'd0, 8'o220});
    cpu_ipl = 3'd5;
    tick();
    check_idle("ipl_withdraw");
    tick();
    check_val("ipl_still_masked", {31'd0, cpu_int}, 32'd0);
    dev_int = '0;
    cpu_ipl = 3'd0;
    tick();

    // Ack coinciding with withdrawal still acks.
    dev_int = 4'b0001;
    wait_post();
    sb_q.push_back('{dev: 0, vec: 8'o60});
    cpu_ack = 1'b1;
    dev_int = 4'b0000;
    tick();
    cpu_ack = 1'b0;
    check_val("wd_ack_wins", {28'd0, dev_ack}, 32'd1);
    tick();
    tick();

    // Withdrawal alone: no ack.
    dev_int = 4'b0010;
    tick();
    check_val("wd_post", {31'd0, cpu_int}, 32'd1);
    dev_int = 4'b0000;
    tick();
    check_idle("wd_alone");
    tick();

    // Vector change while posted is ignored.
    dev_int = 4'b0100;
    tick();
    dev_vector[23:16] = 8'o177;
    tick();
    check_val("vec_latched", {24'd0, cpu_vector}, {24'd0, 8'o100});
    grant(2, 8'o100, 3'd6);
    dev_vector[23:16] = 8'o100;

    // Reset while posted.
    dev_int = 4'b0001;
    tick();
    check_val("rst_post_pre", {31'd0, cpu_int}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("rst_posted");
    dev_int = '0;
    tick();
    check_val("rst_posted_noack", {28'd0, dev_ack}, 32'd0);

    // Reset while in ACK: the pulse already visible is the only one.
    dev_int = 4'b0001;
    wait_post();
    sb_q.push_back('{dev: 0, vec: 8'o60});
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("rst_ack");
    dev_int = '0;
    tick();
    check_val("rst_ack_noack", {28'd0, dev_ack}, 32'd0);

    // Higher-level request arriving while dev0 is posted.
    dev_int = 4'b0001;
    wait_post();
    check_val("pre_vec0", {24'd0, cpu_vector}, {24'd0, 8'o60});
    dev_int = 4'b0101;
    tick();
    check_val("pre_int_held", {31'd0, cpu_int}, 32'd1);
`ifdef UNIBUS_INT_PREEMPT_EN
    check_val("pre_vec_switch", {24'd0, cpu_vector}, {24'd0, 8'o100});
    grant(2, 8'o100, 3'd6);
    grant(0, 8'o60,  3'd4);
`else
    check_val("pre_vec_kept", {24'd0, cpu_vector}, {24'd0, 8'o60});
    grant(0, 8'o60,  3'd4);
    grant(2, 8'o100, 3'd6);
`endif

    tick();
    tick();
    check_val("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/unibus_int_arb.md
Name: unibus_int_arb

Overview:
- Interrupt arbiter between the iopage devices (tt console, disk, line clock, spare) and the CPU's single interrupt/vector/acknowledge path.
- Selects the highest-priority eligible bus request and presents its vector to the CPU.
- Routes the CPU's acknowledge back as a one-cycle per-device interrupt_ack.
- Guards against re-granting a request the device has not yet dropped.

Parameters:
- N_DEV, 4, number of requesting devices.
- DEV_LEVELS, 12'o4654, BR level per device, 3 bits each; device i uses bits [3i+2:3i]. Default: dev0 tt=4, dev1 disk=5, dev2 clock=6, dev3 spare=4.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- dev_int  in  N_DEV  per-device interrupt request (level)
- dev_vector  in  8*N_DEV  per-device vector; device i uses bits [8i+7:8i]
- dev_ack  out  N_DEV  per-device interrupt_ack, one-cycle pulse
- cpu_ipl  in  3  current CPU priority, PSW[7:5]
- cpu_int  out  1  interrupt request to CPU
- cpu_vector  out  8  vector of the posted winner
- cpu_level  out  3  BR level of the posted winner
- cpu_ack  in  1  CPU takes the posted interrupt, one-cycle pulse

Behaviour:
- Clock and reset (already decided): reset is synchronous and active-high; clock is clk.
- Reset: state IDLE; dev_ack=0, cpu_int=0, cpu_vector=0, cpu_level=0; latched winner cleared. Reset in any state abandons the handshake and issues no dev_ack.
- Eligibility: device i is eligible when dev_int[i]=1 and level[i] > cpu_ipl (strictly greater).
- Winner: the highest level wins; ties go to the lowest index.
- States:
  - IDLE: if any device is eligible, latch winner index, dev_vector slice and level, then go to POSTED. cpu_int rises the cycle after dev_int is first sampled eligible (1-cycle latency).
  - POSTED: cpu_int=1; cpu_vector and cpu_level hold the latched values, stable for the whole state.
    - If cpu_ack=1, go to ACK.
    - Otherwise, if the winner's dev_int=0 or cpu_ipl >= latched level (withdrawal), go to IDLE with no dev_ack.
    - cpu_ack has priority over a simultaneous withdrawal: the vector has already been taken, so ACK is still issued.
  - ACK: dev_ack[winner]=1 for exactly one cycle; cpu_int=0; cpu_vector still held. Next state is GUARD.
  - GUARD: all outputs 0 for one cycle, giving the device a registered cycle to clear its request. Next state is IDLE.
- Requests from non-winners are ignored outside IDLE and are re-arbitrated on return to IDLE.
- Minimum spacing: two successive grants are at least 4 cycles apart (POSTED, ACK, GUARD, IDLE eval).
- Outputs: dev_ack is one-hot or zero at all times. cpu_vector=0 and cpu_level=0 in IDLE and GUARD.
- A dev_vector change during POSTED has no effect; the vector latched in IDLE is used.
- Unused levels: a device with level 0 is never eligible.

Optional Feature:
- Macro: UNIBUS_INT_PREEMPT_EN.
- Defined: in POSTED, when no cpu_ack is present and an eligible device has a level strictly greater than the latched level, re-latch that device's index, vector and level. The new cpu_vector appears the next cycle, cpu_int stays 1, and the state stays POSTED.
- cpu_ack in the same cycle as a preempting request acks the old winner.
- Not defined: the winner stays latched until cpu_ack or withdrawal.

Test Plan:
- Single request:
  - Stimulus: cpu_ipl=0; dev_int[0]=1 with vector 8'o64 (tt tx); cpu_ack pulsed 3 cycles after cpu_int.
  - Required: cpu_int=1 and cpu_vector=8'o64, cpu_level=4 one cycle later; dev_ack=4'b0001 for exactly one cycle after cpu_ack; cpu_int=0 during ACK and GUARD.
- Priority and tie:
  - Stimulus: dev_int=4'b1111 with vectors 60/220/100/300 (octal).
  - Required: first grant dev2 (level 6, vector 8'o100); then dev1 (8'o220); then dev0 (8'o60); dev3 last (tie at 4, lowest index first).
- IPL masking:
  - Stimulus: cpu_ipl=5 with dev_int=4'b0011.
  - Required: cpu_int stays 0.
  - Stimulus: cpu_ipl dropped to 4.
  - Required: dev1 posted next cycle. Raising cpu_ipl to 5 while POSTED withdraws with no dev_ack.
- Withdrawal vs ack:
  - Stimulus: winner dev_int drops in the same cycle cpu_ack=1.
  - Required: dev_ack still pulses for that device.
  - Stimulus: dev_int drops alone.
  - Required: back to IDLE, no dev_ack.
- Reset mid-handshake:
  - Stimulus: assert reset in POSTED and, separately, in ACK.
  - Required: all outputs 0 the next cycle; no dev_ack pulse after reset.
- Preempt (UNIBUS_INT_PREEMPT_EN):
  - Stimulus: dev0 posted; dev2 raises request.
  - Required: cpu_vector switches to dev2's vector next cycle, cpu_int stays 1, ack goes to dev2.
  - Without the macro: dev0 is acked first.
